// File: rtl/alu_status_pkg.sv
// Shared types for the ALU status unit: op classes, branch condition codes, NZCV flag layout
// and the condition evaluator used by the branch mux.
package alu_status_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MUL   = 4'd2,
    OP_DIV   = 4'd3,
    OP_MOD   = 4'd4,
    OP_POW   = 4'd5,
    OP_SHIFT = 4'd6,
    OP_AND   = 4'd7,
    OP_OR    = 4'd8,
    OP_XOR   = 4'd9,
    OP_MISC  = 4'd10
  } op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic cond_eval(input flags_t f, input cond_e cc);
    logic r;
    r = 1'b0;
    case (cc)
      COND_EQ: r = f.z;
      COND_NE: r = ~f.z;
      COND_CS: r = f.c;
      COND_CC: r = ~f.c;
      COND_MI: r = f.n;
      COND_PL: r = ~f.n;
      COND_VS: r = f.v;
      COND_VC: r = ~f.v;
      COND_HI: r = f.c & ~f.z;
      COND_LS: r = ~f.c | f.z;
      COND_GE: r = (f.n == f.v);
      COND_LT: r = (f.n != f.v);
      COND_GT: r = ~f.z & (f.n == f.v);
      COND_LE: r = f.z | (f.n != f.v);
      COND_AL: r = 1'b1;
      COND_NV: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_status_unit_if.sv
// Bus between the ALU result mux / control unit and the status unit.
interface alu_status_unit_if #(parameter int N = 5);
  logic           valid_i;
  logic [3:0]     sel_i;
  logic [N-1:0]   a_i;
  logic [N-1:0]   b_i;
  logic [2*N-1:0] res_i;
  logic           push_i;
  logic           pop_i;
  logic [3:0]     cond_i;
  logic           clr_so_i;
  logic [3:0]     flags_o;
  logic           cond_o;
  logic           full_o;
  logic           empty_o;
  logic           err_o;
  logic           so_o;

  modport master (
    output valid_i, sel_i, a_i, b_i, res_i, push_i, pop_i, cond_i, clr_so_i,
    input  flags_o, cond_o, full_o, empty_o, err_o, so_o
  );

  modport slave (
    input  valid_i, sel_i, a_i, b_i, res_i, push_i, pop_i, cond_i, clr_so_i,
    output flags_o, cond_o, full_o, empty_o, err_o, so_o
  );
endinterface

// File: rtl/alu_status_unit_flag_lifo.sv
// DEPTH-entry LIFO for saved flag sets; simultaneous push+pop is a no-op,
// overflow/underflow attempts raise a one-cycle error pulse.
module flag_lifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_pop_ok,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_do_push;
  logic          w_do_pop;
  logic [IW-1:0] w_top_idx;
  logic [IW-1:0] w_wr_idx;

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_push = i_push & ~i_pop & ~o_full;
  assign w_do_pop  = i_pop & ~i_push & ~o_empty;
  assign w_top_idx = IW'(r_cnt - CW'(1));
  assign w_wr_idx  = IW'(r_cnt);
  assign o_dout    = r_mem[w_top_idx];
  assign o_pop_ok  = w_do_pop;
  assign o_err     = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= (i_push & ~i_pop & o_full) | (i_pop & ~i_push & o_empty);
      if (w_do_push)     r_cnt <= r_cnt + CW'(1);
      else if (w_do_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

  // Storage is left unreset: entries above the count are never observed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[w_wr_idx] <= i_din;
  end
endmodule

// File: rtl/alu_status_unit.sv
// Registered NZCV status unit with condition evaluation and a flag save/restore stack.
// Optional sticky overflow bit enabled by defining ALU_STATUS_STICKY_OV_EN.
module alu_status_unit
  import alu_status_pkg::*;
#(
  parameter int N     = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_status_unit_if.slave bus
);
  flags_t       w_flags_new;
  flags_t       w_flags_nxt;
  flags_t       r_flags;
  logic [3:0]   w_lifo_top;
  logic         w_pop_ok;

  always_comb begin
    w_flags_new   = '0;
    w_flags_new.z = ~|bus.res_i[N-1:0];
    case (op_e'(bus.sel_i))
      OP_ADD: begin
        w_flags_new.n = bus.res_i[N-1];
        w_flags_new.c = bus.res_i[N];
        w_flags_new.v = (bus.a_i[N-1] == bus.b_i[N-1]) && (bus.res_i[N-1] != bus.a_i[N-1]);
      end
      OP_SUB: begin
        w_flags_new.n = bus.res_i[N-1];
        w_flags_new.c = bus.res_i[N];
        w_flags_new.v = (bus.a_i[N-1] != bus.b_i[N-1]) && (bus.res_i[N-1] != bus.a_i[N-1]);
      end
      OP_MUL: begin
        w_flags_new.n = bus.res_i[N-1];
        w_flags_new.c = bus.res_i[2*N-1];
        w_flags_new.v = |bus.res_i[2*N-1:N];
      end
      OP_DIV: begin
        w_flags_new.n = bus.res_i[N-1];
        w_flags_new.v = (bus.b_i == '0);
      end
      default: ;
    endcase
  end

  flag_lifo #(
    .DEPTH (DEPTH),
    .W     ($bits(flags_t))
  ) u_lifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (bus.push_i),
    .i_pop    (bus.pop_i),
    .i_din    (r_flags),
    .o_dout   (w_lifo_top),
    .o_pop_ok (w_pop_ok),
    .o_full   (bus.full_o),
    .o_empty  (bus.empty_o),
    .o_err    (bus.err_o)
  );

  // A new result wins over a restore; the popped entry is still consumed.
  always_comb begin
    w_flags_nxt = r_flags;
    if (bus.valid_i)   w_flags_nxt = w_flags_new;
    else if (w_pop_ok) w_flags_nxt = flags_t'(w_lifo_top);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_flags <= '0;
    else        r_flags <= w_flags_nxt;
  end

  assign bus.flags_o = r_flags;
  assign bus.cond_o  = cond_eval(r_flags, cond_e'(bus.cond_i));

`ifdef ALU_STATUS_STICKY_OV_EN
  logic r_so;
  always_ff @(posedge clk) begin
    if (!rst_n)                            r_so <= 1'b0;
    else if (bus.valid_i && w_flags_new.v) r_so <= 1'b1;
    else if (bus.clr_so_i)                 r_so <= 1'b0;
  end
  assign bus.so_o = r_so;
`else
  assign bus.so_o = 1'b0;
`endif
endmodule

// File: tb/tb_alu_status_unit.sv
// Scoreboard bench for alu_status_unit: directed scenarios followed by random traffic,
// checked against an arithmetic reference model of the status unit.
module tb_alu_status_unit;
  localparam int N     = 5;
  localparam int DEPTH = 4;
  localparam int M     = 1 << N;
  localparam int HALF  = M / 2;

  logic clk;
  logic rst_n;

  alu_status_unit_if #(.N(N)) bus ();

  alu_status_unit #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] flags;
    logic       cond;
    logic       full;
    logic       empty;
    logic       err;
    logic       so;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [3:0] m_flags = 4'h0;
  logic [3:0] m_stk[$];
  logic       m_err = 1'b0;
  logic       m_so  = 1'b0;

  function automatic int sgn(input int x);
    return (x >= HALF) ? x - M : x;
  endfunction

  function automatic bit ovf(input int s);
    return (s >= HALF) || (s < -HALF);
  endfunction

  // Flags as the ALU would define them, computed from operand arithmetic.
  function automatic logic [3:0] model_flags(input int sel, input int a, input int b, input int res);
    bit n, z, c, v;
    int r;
    n = 0; c = 0; v = 0;
    z = ((res % M) == 0);
    case (sel)
      0: begin r = a + b; n = (r % M) >= HALF; c = r >= M; v = ovf(sgn(a) + sgn(b)); end
      1: begin r = a - b; n = ((r + M) % M) >= HALF; c = a < b; v = ovf(sgn(a) - sgn(b)); end
      2: begin r = a * b; n = (r % M) >= HALF; c = r >= (M * M / 2); v = r >= M; end
      3: begin n = (res % M) >= HALF; v = (b == 0); end
      default: ;
    endcase
    return {n, z, c, v};
  endfunction

  function automatic bit model_cond(input logic [3:0] f, input int cc);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      0: return z;          1: return !z;
      2: return c;          3: return !c;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return c && !z;    9: return !c || z;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int res_of(input int sel, input int a, input int b);
    case (sel)
      0: return a + b;
      1: return ((a < b) ? M : 0) + ((a - b + M) % M);
      2: return a * b;
      3: return (b != 0) ? a / b : M - 1;
      default: return $urandom_range(M * M - 1, 0);
    endcase
  endfunction

  task automatic cyc(input bit rn, input bit v, input int sel, input int a, input int b,
                     input int res, input bit pu, input bit po, input int cc, input bit clr);
    exp_t       e;
    logic [3:0] top;
    bit         popped;
    @(negedge clk);
    rst_n        = rn;
    bus.valid_i  = v;
    bus.sel_i    = 4'(sel);
    bus.a_i      = N'(a);
    bus.b_i      = N'(b);
    bus.res_i    = (2*N)'(res);
    bus.push_i   = pu;
    bus.pop_i    = po;
    bus.cond_i   = 4'(cc);
    bus.clr_so_i = clr;
    popped = 0;
    top    = 4'h0;
    if (!rn) begin
      m_flags = 4'h0;
      m_stk.delete();
      m_err = 0;
      m_so  = 0;
    end else begin
      m_err = (pu && !po && m_stk.size() == DEPTH) || (po && !pu && m_stk.size() == 0);
      if (pu && !po && m_stk.size() < DEPTH) m_stk.push_back(m_flags);
      if (po && !pu && m_stk.size() > 0) begin
        top = m_stk.pop_back();
        popped = 1;
      end
      if (v) m_flags = model_flags(sel, a, b, res);
      else if (popped) m_flags = top;
`ifdef ALU_STATUS_STICKY_OV_EN
      if (v && m_flags[0]) m_so = 1;
      else if (clr) m_so = 0;
`endif
    end
    e.flags = m_flags;
    e.cond  = model_cond(m_flags, cc);
    e.full  = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.err   = m_err;
    e.so    = m_so;
    q.push_back(e);
  endtask

  task automatic op(input int sel, input int a, input int b, input int cc);
    cyc(1, 1, sel, a, b, res_of(sel, a, b), 0, 0, cc, 0);
  endtask

  task automatic idle(input bit pu, input bit po, input int cc);
    cyc(1, 0, 0, 0, 0, 0, pu, po, cc, 0);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("flags", int'(bus.flags_o), int'(e.flags));
      check("cond", int'(bus.cond_o), int'(e.cond));
      check("stack_status", int'({bus.full_o, bus.empty_o, bus.err_o}),
            int'({e.full, e.empty, e.err}));
      check("so", int'(bus.so_o), int'(e.so));
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.valid_i = 0; bus.sel_i = 0; bus.a_i = 0; bus.b_i = 0; bus.res_i = 0;
    bus.push_i = 0; bus.pop_i = 0; bus.cond_i = 0; bus.clr_so_i = 0;

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 14, 0);
    cyc(0, 1, 0, 15, 1, 16, 1, 0, 0, 0);

    // Arithmetic flag cases and condition codes.
    op(0, 5'b01111, 5'b00001, 10);
    idle(0, 0, 11);
    op(1, 5'b00000, 5'b00001, 2);
    idle(0, 0, 4);
    op(2, 5'b00101, 5'b00111, 6);
    op(3, 7, 0, 6);
    cyc(1, 1, 9, 3, 3, 0, 0, 0, 0, 0);
    idle(0, 0, 8);

    // Fill the stack with four distinct flag sets, then overflow it.
    op(0, 5'b01111, 5'b00001, 14); idle(1, 0, 14);
    op(1, 5'b00000, 5'b00001, 14); idle(1, 0, 14);
    op(2, 5'b00101, 5'b00111, 14); idle(1, 0, 14);
    cyc(1, 1, 9, 0, 0, 0, 0, 0, 14, 0); idle(1, 0, 14);
    op(7, 1, 1, 14);
    idle(1, 0, 14);
    idle(0, 0, 14);
    for (int i = 0; i < 5; i++) idle(0, 1, 14);
    idle(0, 0, 14);

    // Update beats restore; push+pop is a no-op.
    op(0, 5'b01111, 5'b00001, 14); idle(1, 0, 14);
    op(1, 5'b00000, 5'b00001, 14); idle(1, 0, 14);
    cyc(1, 1, 2, 5, 7, 35, 0, 1, 6, 0);
    idle(1, 1, 14);
    idle(0, 1, 14);

    // Sticky overflow, then reset with entries stacked.
    op(0, 5'b01111, 5'b00001, 14);
    idle(1, 0, 14); idle(1, 0, 14); idle(1, 0, 14);
    op(9, 1, 2, 14);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(0, 0, 1);
    op(0, 5'b01000, 5'b01000, 6);
    op(9, 1, 2, 14);
    op(1, 9, 3, 14);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 14, 1);
    idle(0, 0, 14);
    cyc(1, 1, 0, 8, 8, 16, 0, 0, 14, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int sel, a, b;
      bit rn;
      sel = $urandom_range(15, 0);
      a   = $urandom_range(M - 1, 0);
      b   = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(M - 1, 0);
      rn  = ($urandom_range(63, 0) != 0);
      cyc(rn, $urandom_range(9, 0) < 6, sel, a, b, res_of(sel, a, b),
          $urandom_range(9, 0) < 3, $urandom_range(9, 0) < 3,
          $urandom_range(15, 0), $urandom_range(9, 0) == 0);
    end

    idle(0, 0, 14);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
